// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction ROM port, redirect request and the
// decode-side valid/ready instruction stream.
interface instr_fetch_unit_if #(
    parameter int DEPTH = 2
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr_data;
    logic [31:0]   instr_pc;
    logic          misalign_err;
    logic [CW-1:0] fifo_count;

    // fetch unit side
    modport master (
        output imem_addr, instr_valid, instr_data, instr_pc, misalign_err, fifo_count,
        input  imem_data, redirect_valid, redirect_pc, instr_ready
    );

    // ROM / decode / branch-unit side
    modport slave (
        input  imem_addr, instr_valid, instr_data, instr_pc, misalign_err, fifo_count,
        output imem_data, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives a combinational ROM from the fetch PC and queues
// {word, pc} pairs in a small prefetch FIFO drained by decode. A redirect
// flushes the FIFO and restarts fetch at the (word-aligned) target.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic              clk,
    input logic              reset,
    instr_fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][31:0] q_data;
    logic [DEPTH-1:0][31:0] q_pc;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [CW-1:0]          count;
    logic [31:0]            pc;
    logic                   mis;
    logic                   valid;
    logic                   pop;
    logic                   push;

    // Handshake decode; a full FIFO still accepts a word when the head leaves.
    always_comb begin
        valid = (count != '0);
        pop   = valid & bus.instr_ready;
        push  = !bus.redirect_valid & ((count < CW'(DEPTH)) | pop);
    end

    // Fetch PC, FIFO pointers and occupancy; reset beats redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= {RESET_PC[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect_valid) begin
            pc     <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                pc     <= pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_data[wr_ptr] <= bus.imem_data;
            q_pc[wr_ptr]   <= pc;
        end
    end

    // One-cycle flag for a redirect target that was not word aligned.
    always_ff @(posedge clk) begin
        if (reset)
            mis <= 1'b0;
        else
            mis <= bus.redirect_valid & (|bus.redirect_pc[1:0]);
    end

    assign bus.imem_addr    = pc;
    assign bus.instr_valid  = valid;
    assign bus.instr_data   = valid ? q_data[rd_ptr] : 32'h0;
    assign bus.instr_pc     = valid ? q_pc[rd_ptr]   : 32'h0;
    assign bus.misalign_err = mis;
    assign bus.fifo_count   = count;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run
// compared against a queue-based model of the fetch stage.
module tb_instr_fetch_unit;
    localparam int          DEPTH   = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.DEPTH(DEPTH)) bus ();
    instr_fetch_unit_if #(.DEPTH(DEPTH)) bus2 ();

    // ROM word k holds 0x1000_0000 + k
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign bus.imem_data  = rom(bus.imem_addr);
    assign bus2.imem_data = rom(bus2.imem_addr);

    instr_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    instr_fetch_unit #(.RESET_PC(RST_PC2), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    // behavioural model: queue of fetched {data, pc} plus fetch PC
    typedef struct { logic [31:0] d; logic [31:0] p; } ent_t;
    ent_t        q[$];
    logic [31:0] m_pc;
    logic        m_mis;

    task automatic model_edge();
        bit pop, push;
        if (reset) begin
            q.delete();
            m_pc  = RST_PC & ~32'h3;
            m_mis = 1'b0;
        end else begin
            pop   = (q.size() > 0) && bus.instr_ready;
            push  = !bus.redirect_valid && ((q.size() < DEPTH) || pop);
            m_mis = bus.redirect_valid && (bus.redirect_pc % 4 != 0);
            if (bus.redirect_valid) begin
                q.delete();
                m_pc = bus.redirect_pc & ~32'h3;
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back('{rom(m_pc), m_pc});
                    m_pc = m_pc + 4;
                end
            end
        end
    endtask

    // one clock: inputs were set before the edge, outputs sampled at negedge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.instr_ready = 1'b1;
        bus.redirect_pc = 32'h0;
        do_reset();
        vectors++; if (bus.fifo_count !== 2'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
        vectors++; if (bus.instr_data !== 32'h0 || bus.instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_head: got %h/%h want 0/0", bus.instr_data, bus.instr_pc); end
        vectors++; if (bus.misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_mis: got %b want 0", bus.misalign_err); end
        vectors++; if (bus.imem_addr !== RST_PC) begin miscompares++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, RST_PC); end
    endtask

    task automatic test_stream();
        do_reset();
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * k) || bus.instr_data !== 32'h1000_0000 + 32'(k)) begin
                miscompares++;
                $display("FAIL stream[%0d]: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, bus.instr_valid, bus.instr_pc, bus.instr_data, 4 * k, 32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        vectors++; if (bus.fifo_count !== 2'd2) begin miscompares++; $display("FAIL bp_count: got %0d want 2", bus.fifo_count); end
        vectors++; if (bus.imem_addr !== 32'h8) begin miscompares++; $display("FAIL bp_addr: got %h want 8", bus.imem_addr); end
        vectors++; if (bus.instr_pc !== 32'h0 || bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL bp_head: got pc=%h v=%b want 0/1", bus.instr_pc, bus.instr_valid); end
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * k)) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: got v=%b pc=%h want 1/%h", k, bus.instr_valid, bus.instr_pc, 4 * k);
            end
            tick();
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        tick();
        bus.redirect_valid = 1'b0;
        vectors++;
        if (bus.fifo_count !== 2'd0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h40 || bus.misalign_err !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_flush: got cnt=%0d v=%b addr=%h mis=%b want 0/0/40/0", bus.fifo_count, bus.instr_valid, bus.imem_addr, bus.misalign_err);
        end
        tick();
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40 || bus.instr_data !== 32'h1000_0010) begin
            miscompares++;
            $display("FAIL redir_target: got v=%b pc=%h d=%h want 1/40/10000010", bus.instr_valid, bus.instr_pc, bus.instr_data);
        end
    endtask

    task automatic test_misalign();
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h42;
        tick();
        bus.redirect_valid = 1'b0;
        vectors++;
        if (bus.misalign_err !== 1'b1 || bus.imem_addr !== 32'h40) begin
            miscompares++;
            $display("FAIL misalign_pulse: got mis=%b addr=%h want 1/40", bus.misalign_err, bus.imem_addr);
        end
        tick();
        vectors++;
        if (bus.misalign_err !== 1'b0 || bus.instr_pc !== 32'h40) begin
            miscompares++;
            $display("FAIL misalign_clear: got mis=%b pc=%h want 0/40", bus.misalign_err, bus.instr_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000; exp_pc[3] = 32'h0000_0004;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== exp_pc[k] || bus2.instr_data !== rom(exp_pc[k])) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got v=%b pc=%h d=%h want 1/%h/%h", k, bus2.instr_valid, bus2.instr_pc, bus2.instr_data, exp_pc[k], rom(exp_pc[k]));
            end
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        bus.instr_ready = 1'b0;
        tick(); tick();
        vectors++; if (bus.fifo_count !== 2'd2) begin miscompares++; $display("FAIL rstpri_pre: got %0d want 2", bus.fifo_count); end
        reset = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h42;
        tick();
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        vectors++;
        if (bus.fifo_count !== 2'd0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== RST_PC || bus.misalign_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rstpri: got cnt=%0d v=%b addr=%h mis=%b want 0/0/%h/0", bus.fifo_count, bus.instr_valid, bus.imem_addr, bus.misalign_err, RST_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] e_d, e_p;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.instr_ready    = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 9) == 0);
            bus.redirect_pc    = $urandom;
            reset              = ($urandom_range(0, 49) == 0);
            tick();
            reset = 1'b0;
            e_d = (q.size() > 0) ? q[0].d : 32'h0;
            e_p = (q.size() > 0) ? q[0].p : 32'h0;
            vectors++;
            if (bus.instr_valid !== (q.size() > 0) || bus.instr_data !== e_d || bus.instr_pc !== e_p ||
                bus.fifo_count !== 2'(q.size()) || bus.imem_addr !== m_pc || bus.misalign_err !== m_mis) begin
                miscompares++;
                $display("FAIL random[%0d]: got v=%b d=%h pc=%h cnt=%0d addr=%h mis=%b want v=%b d=%h pc=%h cnt=%0d addr=%h mis=%b",
                         n, bus.instr_valid, bus.instr_data, bus.instr_pc, bus.fifo_count, bus.imem_addr, bus.misalign_err,
                         q.size() > 0, e_d, e_p, q.size(), m_pc, m_mis);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.instr_ready     = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'h0;
        bus2.instr_ready    = 1'b1;
        m_pc  = RST_PC;
        m_mis = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misalign();
        test_wrap();
        test_reset_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-fetch stage that drives the word-addressed instruction ROM and delivers instructions downstream to decode. It holds the fetch PC and reads the combinational ROM each cycle. Fetched words, each paired with its PC, go into a small prefetch FIFO, which the consumer drains with a valid/ready handshake. A redirect input (branch/jump) flushes the FIFO and restarts fetch at a new PC.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
DEPTH, 2, prefetch FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
imem_addr  output  32  byte address to instruction ROM; always equals fetch PC (combinational)
imem_data  input  32  instruction word returned combinationally for imem_addr
redirect_valid  input  1  one-cycle request to restart fetch
redirect_pc  input  32  redirect target byte address
instr_valid  output  1  FIFO head holds a valid instruction
instr_ready  input  1  consumer accepts the head this cycle
instr_data  output  32  instruction at FIFO head
instr_pc  output  32  byte address of instr_data
misalign_err  output  1  registered one-cycle pulse: redirect_pc[1:0] was nonzero
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous; clk edge with reset=1):
  - fetch PC <= RESET_PC, with bits [1:0] forced to 0.
  - FIFO emptied: fifo_count=0, instr_valid=0.
  - instr_data=0, instr_pc=0, misalign_err=0.
- Reset has priority over redirect, push and pop.
- Empty-FIFO outputs: instr_data and instr_pc read 0 whenever the FIFO is empty.
- pop = instr_valid & instr_ready.
- push = !redirect_valid & (fifo_count < DEPTH | pop).
  - Full FIFO with a simultaneous pop still pushes.
  - Pushed entry: {imem_data, fetch PC}.
- On push: fetch PC <= fetch PC + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- No push: fetch PC holds and imem_addr is stable.
- FIFO ordering: strict FIFO; instr_data/instr_pc come from the head entry, with no extra register stage.
- Occupancy update: fifo_count += push - pop.
- Redirect (redirect_valid=1 at an edge):
  - FIFO cleared, fifo_count <= 0.
  - fetch PC <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle.
- Redirect with simultaneous pop: the pop still counts as accepted; downstream owns that instruction.
- misalign_err <= |redirect_pc[1:0] when redirect_valid, else 0.
- Latency:
  - After reset release, the first instruction (at RESET_PC) is valid 1 cycle later.
  - After a redirect at edge N, instr_valid=0 in cycle N+1.
  - The target instruction is valid in cycle N+2.
- Steady-state throughput: 1 instruction/cycle with instr_ready held high.
- Back-pressure: with instr_ready=0, the FIFO fills to DEPTH and then fetch stalls.
  - Head entry and its outputs hold stable while instr_valid=1 & instr_ready=0.
- Redirect while full or stalled: the flush applies regardless of occupancy.

Test Plan:
- Reset, then instr_ready=1 with ROM[k]=32'h1000_0000+k -> from cycle 1, instr_pc = 0,4,8,12…, instr_data = 32'h1000_0000,…0001,…0002, one per cycle, no bubbles.
- instr_ready=0 for 5 cycles after reset -> fifo_count reaches 2 and stays there; imem_addr frozen at 32'h8; instr_pc=0 held; on ready=1, pcs 0,4,8 delivered back-to-back.
- redirect_valid=1 with redirect_pc=32'h40 while the FIFO is full -> next cycle fifo_count=0, instr_valid=0, imem_addr=32'h40; the cycle after, instr_pc=32'h40 and instr_data=ROM[16].
- redirect_pc=32'h42 -> misalign_err=1 for exactly one cycle; fetch resumes at 32'h40.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert reset mid-stream with the FIFO holding 2 entries and redirect_valid=1 -> FIFO empty and fetch PC=RESET_PC; redirect ignored, misalign_err=0.
